// File: rtl/icache_pkg.sv
// Shared types and width helpers for the N-way instruction cache.
package icache_pkg;

   typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_BUS, AR, FILL, RESPOND} icache_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   function automatic int off_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
      return addr_w - $clog2(line_bytes) - $clog2(sets);
   endfunction

   // Counter width that stays at least one bit for single-entry ranges.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_fill_buffer.sv
// Collects R-channel beats into one cache line; line also carries the beat
// landing this cycle so the last beat can be committed without a bubble.
module icache_fill_buffer
   import icache_pkg::*;
#(
   parameter int LINE_W     = 512,
   parameter int AXI_DATA_W = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rvalid,
   input  logic                  rready,
   input  logic                  rlast,
   input  logic [AXI_DATA_W-1:0] rdata,
   output logic [LINE_W-1:0]     line,
   output logic                  line_done
);

   localparam int BEATS  = LINE_W / AXI_DATA_W;
   localparam int BEAT_W = cnt_w(BEATS);

   logic [BEAT_W-1:0] beat_cnt;
   logic [LINE_W-1:0] line_q;
   logic              beat_fire;

   assign beat_fire = rvalid && rready;
   assign line_done = beat_fire && rlast;

   always_comb begin
      line = line_q;
      for (int b = 0; b < BEATS; b++) begin
         if (beat_fire && beat_cnt == BEAT_W'(b))
            line[b*AXI_DATA_W +: AXI_DATA_W] = rdata;
      end
   end

   // rlast restarts the count so an over-long burst cannot skew the next line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         beat_cnt <= '0;
         line_q   <= '0;
      end else if (beat_fire) begin
         line_q   <= line;
         beat_cnt <= rlast ? '0 : beat_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with a single
// outstanding fetch and whole-line AXI4 INCR refills.
module icache_nway
   import icache_pkg::*;
#(
   parameter int LINE_BYTES = 64,
   parameter int SETS       = 32,
   parameter int WAYS       = 2,
   parameter int ADDR_W     = 64,
   parameter int AXI_DATA_W = 64,
   parameter int INSTR_W    = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic [ADDR_W-1:0]     req_addr,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [INSTR_W-1:0]    resp_data,
   input  logic                  resp_ready,
   input  logic                  abort,
   input  logic                  flush,
   input  logic                  dcache_busy,
   output logic                  icache_busy,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   input  logic                  m_axi_rlast,
   input  logic [AXI_DATA_W-1:0] m_axi_rdata
);

   localparam int OFF    = off_w(LINE_BYTES);
   localparam int IDX    = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, SETS);
   localparam int WORD_W = OFF - 2;
   localparam int LINE_W = LINE_BYTES * 8;
   localparam int BEATS  = LINE_W / AXI_DATA_W;
   localparam int WAY_W  = cnt_w(WAYS);

   icache_state_e state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic              aborted_q;
   logic              flush_pend_q;
   logic [INSTR_W-1:0] resp_data_q;

   logic [SETS-1:0][WAYS-1:0]             valid_q;
   logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag_q;
   logic [SETS-1:0][WAYS-1:0][LINE_W-1:0] data_q;
   logic [SETS-1:0][WAY_W-1:0]            rr_q;

   logic [IDX-1:0]    set_a;
   logic [TAG_W-1:0]  tag_a;
   logic [WORD_W-1:0] word_a;
   logic [WAYS-1:0]   way_hit;
   logic              hit;
   logic [LINE_W-1:0] hit_line;
   logic [LINE_W-1:0] fill_line;
   logic              line_done;
   logic              fill_we;
   logic              do_flush;
   logic              set_full;
   logic [WAY_W-1:0]  victim;
   logic [WAY_W-1:0]  rr_next;

   assign set_a    = addr_q[OFF +: IDX];
   assign tag_a    = addr_q[ADDR_W-1 -: TAG_W];
   assign word_a   = addr_q[OFF-1:2];
   assign do_flush = flush || flush_pend_q;
   assign fill_we  = (state_q == FILL) && line_done;

   function automatic logic [INSTR_W-1:0] pick_word(input logic [LINE_W-1:0] l,
                                                    input logic [WORD_W-1:0] w);
      return l[w*INSTR_W +: INSTR_W];
   endfunction

   generate
      for (genvar w = 0; w < WAYS; w++) begin : g_way
         assign way_hit[w] = valid_q[set_a][w] && (tag_q[set_a][w] == tag_a);
      end
   endgenerate

   assign hit = |way_hit;

   always_comb begin
      hit_line = '0;
      for (int w = 0; w < WAYS; w++)
         if (way_hit[w]) hit_line = data_q[set_a][w];
   end

   // Lowest invalid way wins; a full set falls back to its round-robin pointer.
   always_comb begin
      victim   = rr_q[set_a];
      set_full = &valid_q[set_a];
      for (int w = WAYS-1; w >= 0; w--)
         if (!valid_q[set_a][w]) victim = WAY_W'(w);
      rr_next = (rr_q[set_a] == WAY_W'(WAYS-1)) ? '0 : rr_q[set_a] + 1'b1;
   end

   icache_fill_buffer #(
      .LINE_W     (LINE_W),
      .AXI_DATA_W (AXI_DATA_W)
   ) u_fill (
      .clock     (clock),
      .reset     (reset),
      .rvalid    (m_axi_rvalid),
      .rready    (m_axi_rready),
      .rlast     (m_axi_rlast),
      .rdata     (m_axi_rdata),
      .line      (fill_line),
      .line_done (line_done)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (!do_flush && req_valid) state_d = LOOKUP;
         LOOKUP:   if (abort)             state_d = IDLE;
                   else if (hit)          state_d = RESPOND;
                   else if (dcache_busy)  state_d = WAIT_BUS;
                   else                   state_d = AR;
         WAIT_BUS: if (abort)             state_d = IDLE;
                   else if (!dcache_busy) state_d = AR;
         AR:       if (m_axi_arready)     state_d = FILL;
         FILL:     if (line_done)         state_d = (aborted_q || abort) ? IDLE : RESPOND;
         RESPOND:  if (abort || resp_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready     = (state_q == IDLE) && !do_flush;
      resp_valid    = (state_q == RESPOND);
      resp_data     = resp_data_q;
      icache_busy   = (state_q == AR) || (state_q == FILL);
      m_axi_arvalid = (state_q == AR);
      m_axi_rready  = (state_q == FILL);
      m_axi_araddr  = '0;
      m_axi_arlen   = '0;
      m_axi_arsize  = '0;
      m_axi_arburst = '0;
      if (state_q == AR) begin
         m_axi_araddr  = {tag_a, set_a, {OFF{1'b0}}};
         m_axi_arlen   = 8'(BEATS - 1);
         m_axi_arsize  = 3'($clog2(AXI_DATA_W / 8));
         m_axi_arburst = AXI_BURST_INCR;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q       <= '0;
         aborted_q    <= 1'b0;
         flush_pend_q <= 1'b0;
         resp_data_q  <= '0;
         valid_q      <= '0;
         rr_q         <= '0;
      end else begin
         if (req_valid && req_ready) addr_q <= req_addr;

         if (state_q == IDLE)
            aborted_q <= 1'b0;
         else if (abort && ((state_q == AR) || (state_q == FILL)))
            aborted_q <= 1'b1;

         // A flush seen mid-transaction waits here and lands in the next IDLE.
         if (state_q == IDLE)  flush_pend_q <= 1'b0;
         else if (flush)       flush_pend_q <= 1'b1;

         if ((state_q == IDLE) && do_flush) begin
            valid_q <= '0;
         end else if (fill_we) begin
            valid_q[set_a][victim] <= 1'b1;
            if (set_full) rr_q[set_a] <= rr_next;
         end

         if ((state_q == LOOKUP) && hit) resp_data_q <= pick_word(hit_line, word_a);
         else if (fill_we)               resp_data_q <= pick_word(fill_line, word_a);
      end
   end

   always_ff @(posedge clock) begin
      if (fill_we) begin
         tag_q[set_a][victim]  <= tag_a;
         data_q[set_a][victim] <= fill_line;
      end
   end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: a small AXI slave model inside fetch()
// serves refills; each test task compares against hand-computed values.
module tb_icache_nway;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [63:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_ready;
   logic        abort;
   logic        flush;
   logic        dcache_busy;
   logic        icache_busy;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [63:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic        m_axi_rlast;
   logic [63:0] m_axi_rdata;

   always #5 clock = ~clock;

   icache_nway #(
      .LINE_BYTES(64), .SETS(32), .WAYS(2), .ADDR_W(64), .AXI_DATA_W(64), .INSTR_W(32)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
      .abort(abort), .flush(flush),
      .dcache_busy(dcache_busy), .icache_busy(icache_busy),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rlast(m_axi_rlast), .m_axi_rdata(m_axi_rdata)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc_cnt = 0;
   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   bit          f_ar, f_busy_ar, f_resp, f_viol;
   logic [63:0] f_araddr;
   logic [7:0]  f_arlen;
   logic [2:0]  f_arsize;
   logic [1:0]  f_arburst;
   logic [31:0] f_data;
   int          f_beats, f_lat, f_resp_cyc, f_ar_cyc, f_rel_cyc;

   // Memory image: word at byte address a (line-relative index in low bits).
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return 32'hC000_0000 | {8'h00, a[23:6], 6'h00} | 32'(a[5:2]);
   endfunction

   // Issues one request and plays the AXI slave; called and returns on a negedge.
   task automatic fetch(input logic [63:0] addr, input int abort_beat,
                        input int flush_beat, input int dbusy_n);
      logic [63:0] line;
      int k, cyc, guard;
      bit ar_done, done;
      line = {addr[63:6], 6'h00};
      f_ar = 0; f_busy_ar = 0; f_resp = 0; f_viol = 0;
      f_araddr = '0; f_arlen = '0; f_arsize = '0; f_arburst = '0; f_data = '0;
      f_beats = 0; f_lat = -1; f_resp_cyc = -1; f_ar_cyc = -1; f_rel_cyc = -1;
      req_valid = 1'b1; req_addr = addr;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clock); guard++;
      end
      @(negedge clock);
      req_valid = 1'b0;
      k = 0; cyc = 1; ar_done = 0; done = 0;
      while (!done && cyc < 200) begin
         dcache_busy = (cyc <= dbusy_n);
         if (!dcache_busy && dbusy_n > 0 && f_rel_cyc < 0) f_rel_cyc = cyc;
         if (dcache_busy && (m_axi_arvalid || icache_busy)) f_viol = 1;
         if (ar_done && k < 8) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = {mem_word(line + 64'(8*k + 4)), mem_word(line + 64'(8*k))};
            m_axi_rlast  = (k == 7);
         end else begin
            m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
         end
         abort = (abort_beat >= 0) && m_axi_rvalid && m_axi_rready && (k == abort_beat);
         flush = (flush_beat >= 0) && m_axi_rvalid && m_axi_rready && (k == flush_beat);
         if (m_axi_rvalid && m_axi_rready) k++;
         m_axi_arready = m_axi_arvalid;
         if (m_axi_arvalid && !f_ar) begin
            f_ar = 1; f_ar_cyc = cyc; f_araddr = m_axi_araddr; f_arlen = m_axi_arlen;
            f_arsize = m_axi_arsize; f_arburst = m_axi_arburst; f_busy_ar = icache_busy;
         end
         if (m_axi_arvalid) ar_done = 1;
         resp_ready = resp_valid;
         if (resp_valid) begin
            f_resp = 1; f_data = resp_data; f_lat = cyc; f_resp_cyc = cyc_cnt; done = 1;
         end
         if (abort_beat >= 0 && k == 8 && req_ready) done = 1;
         @(negedge clock);
         cyc++;
      end
      f_beats = k;
      n_cmp++;
      if (!done) begin
         $display("FAIL fetch_timeout addr=%h: no completion within bound, completion required", addr);
         n_mis++;
      end
      resp_ready = 0; abort = 0; flush = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
      m_axi_arready = 0; dcache_busy = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 0; req_addr = '0; resp_ready = 0; abort = 0; flush = 0;
      dcache_busy = 0; m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0;
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({resp_valid, icache_busy, m_axi_arvalid, m_axi_rready} !== 4'b0000) begin
         $display("FAIL reset_ctrl got %b required 0000",
                  {resp_valid, icache_busy, m_axi_arvalid, m_axi_rready});
         n_mis++;
      end
      n_cmp++;
      if (m_axi_araddr !== 64'h0 || m_axi_arlen !== 8'h0 || resp_data !== 32'h0) begin
         $display("FAIL reset_data araddr=%h arlen=%h resp=%h required all 0",
                  m_axi_araddr, m_axi_arlen, resp_data);
         n_mis++;
      end
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         $display("FAIL idle_ready got %b required 1", req_ready); n_mis++;
      end
   endtask

   task automatic test_cold_miss();
      fetch(64'h1004, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b1 || f_araddr !== 64'h1000) begin
         $display("FAIL cold_ar seen=%b araddr=%h required 1/1000", f_ar, f_araddr); n_mis++;
      end
      n_cmp++;
      if ({f_arlen, f_arsize, f_arburst} !== {8'd7, 3'd3, 2'd1}) begin
         $display("FAIL cold_ar_fields len=%0d size=%0d burst=%0d required 7/3/1",
                  f_arlen, f_arsize, f_arburst); n_mis++;
      end
      n_cmp++;
      if (f_busy_ar !== 1'b1 || f_beats !== 8) begin
         $display("FAIL cold_busy_beats busy=%b beats=%0d required 1/8", f_busy_ar, f_beats); n_mis++;
      end
      n_cmp++;
      if (f_resp !== 1'b1 || f_data !== 32'hC000_1001) begin
         $display("FAIL cold_data resp=%b data=%h required 1/c0001001", f_resp, f_data); n_mis++;
      end
   endtask

   task automatic test_hit();
      fetch(64'h1004, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b0 || f_lat !== 2) begin
         $display("FAIL hit_latency ar=%b lat=%0d required 0/2", f_ar, f_lat); n_mis++;
      end
      n_cmp++;
      if (f_data !== 32'hC000_1001) begin
         $display("FAIL hit_data got %h required c0001001", f_data); n_mis++;
      end
      fetch(64'h103C, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b0 || f_data !== 32'hC000_100F) begin
         $display("FAIL hit_last_word ar=%b data=%h required 0/c000100f", f_ar, f_data); n_mis++;
      end
   endtask

   task automatic test_back_to_back();
      int r1;
      logic [31:0] d1;
      fetch(64'h1008, -1, -1, 0);
      r1 = f_resp_cyc; d1 = f_data;
      fetch(64'h100C, -1, -1, 0);
      n_cmp++;
      if (f_resp_cyc - r1 !== 3) begin
         $display("FAIL b2b_spacing got %0d required 3", f_resp_cyc - r1); n_mis++;
      end
      n_cmp++;
      if (d1 !== 32'hC000_1002 || f_data !== 32'hC000_1003) begin
         $display("FAIL b2b_data got %h/%h required c0001002/c0001003", d1, f_data); n_mis++;
      end
   endtask

   task automatic test_flush_idle();
      fetch(64'h0040, -1, -1, 0);
      fetch(64'h0080, -1, -1, 0);
      flush = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 1'b0) begin
         $display("FAIL flush_ready got %b required 0", req_ready); n_mis++;
      end
      @(negedge clock);
      flush = 1'b0;
      fetch(64'h1004, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b1) begin
         $display("FAIL flush_miss_1000 ar=%b required 1", f_ar); n_mis++;
      end
      fetch(64'h0040, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b1 || f_data !== 32'hC000_0040) begin
         $display("FAIL flush_miss_0040 ar=%b data=%h required 1/c0000040", f_ar, f_data); n_mis++;
      end
      fetch(64'h0080, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b1) begin
         $display("FAIL flush_miss_0080 ar=%b required 1", f_ar); n_mis++;
      end
   endtask

   task automatic test_replacement();
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      fetch(64'h0000, -1, -1, 0);
      fetch(64'h0800, -1, -1, 0);
      fetch(64'h1000, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b1) begin
         $display("FAIL rr_third_fill ar=%b required 1", f_ar); n_mis++;
      end
      fetch(64'h0800, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b0 || f_data !== 32'hC000_0800) begin
         $display("FAIL rr_keep_0800 ar=%b data=%h required 0/c0000800", f_ar, f_data); n_mis++;
      end
      fetch(64'h0000, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b1) begin
         $display("FAIL rr_evicted_0000 ar=%b required 1", f_ar); n_mis++;
      end
      fetch(64'h1000, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b0 || f_data !== 32'hC000_1000) begin
         $display("FAIL rr_keep_1000 ar=%b data=%h required 0/c0001000", f_ar, f_data); n_mis++;
      end
   endtask

   task automatic test_abort();
      fetch(64'h0C40, 2, -1, 0);
      n_cmp++;
      if (f_beats !== 8 || f_resp !== 1'b0) begin
         $display("FAIL abort_fill beats=%0d resp=%b required 8/0", f_beats, f_resp); n_mis++;
      end
      fetch(64'h0C40, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b0 || f_data !== 32'hC000_0C40) begin
         $display("FAIL abort_line_kept ar=%b data=%h required 0/c0000c40", f_ar, f_data); n_mis++;
      end
   endtask

   task automatic test_flush_fill();
      fetch(64'h2000, -1, 3, 0);
      n_cmp++;
      if (f_resp !== 1'b1 || f_data !== 32'hC000_2000) begin
         $display("FAIL flush_fill_resp resp=%b data=%h required 1/c0002000", f_resp, f_data); n_mis++;
      end
      fetch(64'h2000, -1, -1, 0);
      n_cmp++;
      if (f_ar !== 1'b1) begin
         $display("FAIL flush_fill_invalid ar=%b required 1", f_ar); n_mis++;
      end
   endtask

   task automatic test_dcache_busy();
      fetch(64'h3000, -1, -1, 10);
      n_cmp++;
      if (f_viol !== 1'b0) begin
         $display("FAIL dbusy_hold got violation=%b required 0", f_viol); n_mis++;
      end
      n_cmp++;
      if (f_rel_cyc !== 11 || f_ar_cyc !== 12) begin
         $display("FAIL dbusy_ar_timing rel=%0d ar=%0d required 11/12", f_rel_cyc, f_ar_cyc); n_mis++;
      end
      n_cmp++;
      if (f_data !== 32'hC000_3000) begin
         $display("FAIL dbusy_data got %h required c0003000", f_data); n_mis++;
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_back_to_back();
      test_flush_idle();
      test_replacement();
      test_abort();
      test_flush_fill();
      test_dcache_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
